cfg_param_reader: RTL and testbench
===================================

# cfg_param_reader

Read-side responder for the package constant table: accepts an index request on a valid/ready handshake, looks the 32-bit constant up in the shared constant table, and streams it out as four bytes on a byte-wide valid/ready stream with a last flag. It sits between the configuration bus front end and any consumer that needs package constants at run time, for example a debug or introspection port. It is the consumer-side counterpart of the package that declares the constants.

## Interface
- `MSB_FIRST`, default 0: byte order; 0 = least-significant byte first, 1 = most-significant byte first.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; reset 0, then 1 in IDLE.
- `req_index`  in  4  table index, 0..15.
- `out_valid`  out  1  byte present; reset 0.
- `out_ready`  in  1  consumer accepts byte.
- `out_data`  out  8  current byte; reset 0.
- `out_last`  out  1  marks the fourth byte; reset 0.
- `out_err`  out  1  index out of range; held for all four bytes; reset 0.
- `out_par`  out  1  even parity of `out_data`; present only with `CFG_PARAM_READER_PARITY_EN`; reset 0.

## Operation
- Table, indices 0..12: 555, 556, 560, 561, 562, 557, 558, 559, 666, 667, 777, 778, 779.
- `NUM_ENTRIES` = 13.
- **FSM states:** IDLE, SEND.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid & req_ready`, the word is loaded into a 32-bit shift register, the byte counter is cleared to 0, and the FSM moves to SEND.
- **Out-of-range index (13..15):** the word is 0, and `out_err` = 1 for the whole response.
- **SEND:**
  - `req_ready` = 0 and `out_valid` = 1.
  - `out_data` is the current byte, selected by `MSB_FIRST`.
  - `out_data`, `out_last` and `out_err` stay stable while `out_valid & !out_ready`.
- **Byte handshake:** on `out_valid & out_ready`, the register shifts by 8 and the counter increments.
- **Last byte:** `out_last` = 1 when counter == 3. The handshake on that byte returns the FSM to IDLE, and `out_valid` falls the next cycle.
- **No overlap:** a new request is never accepted in the same cycle as the last-byte handshake. `req_ready` rises one cycle after the last byte is taken.
- **Counter width:** 2 bits; it wraps to 0 only by reload, never by overflow in use.
- **Reset mid-response:** all outputs go to 0 immediately, the FSM goes to IDLE, and the partial response is discarded. No byte is emitted after reset release until a new request arrives.

## Timing
- Request accepted at edge N; first byte valid from edge N+1.
- Minimum response is 4 cycles with `out_ready` held high; the next `req_ready` is at N+5.
- Steady-state throughput: one request per 5 cycles.
- No combinational path from `out_ready` or `req_valid` to any output. All outputs are registered or decoded from registered state.

## Configuration
- **`CFG_PARAM_READER_PARITY_EN` defined:**
  - `out_par` port exists, computed as `^out_data` (even parity).
  - Parity is registered together with the byte, so it is stable under backpressure.
- **Not defined:** the port and its logic are absent, and the remaining behaviour is identical.

## Structure
- **Package `cfg_param_pkg` holds:**
  - the `NUM_ENTRIES` constant;
  - `IDX_W` = 4;
  - the constant table as a localparam unpacked array of int;
  - the `state_e` enum (IDLE, SEND).
- **Sub-module `param_byte_serializer`:**
  - loads a 32-bit word, handles the byte counter, `out_last` and backpressure;
  - parameterised by `MSB_FIRST`;
  - the top holds the FSM, lookup and error decode.

## Test plan
- **Index 0, `out_ready` = 1, `MSB_FIRST` = 0** -> bytes 0x2B, 0x02, 0x00, 0x00 on 4 consecutive cycles. `out_last` only on the 4th byte, `out_err` = 0, `req_ready` back at accept + 5.
- **Index 12, `MSB_FIRST` = 1** -> bytes 0x00, 0x00, 0x03, 0x0B, `out_last` on 0x0B.
- **Index 14** -> bytes 00, 00, 00, 00 with `out_err` = 1 on all four. The next request, index 8, returns 0x9A, 0x02, 0x00, 0x00 with `out_err` = 0.
- **Index 1 with `out_ready` toggling 1, 0, 0, 1, …** -> bytes 0x2C, 0x02, 0x00, 0x00 in order. Data, last and err are held during stalls, with no duplicated or dropped bytes.
- **`rst_n` low after the second byte of index 9 (0x29B)** -> `out_valid` = 0 asynchronously, and `req_ready` = 1 one cycle after release. A new request for index 0 yields 0x2B first.
- **Parity build, index 0** -> `out_par` = 0, 1, 0, 0 for 0x2B, 0x02, 0x00, 0x00.

Source files
------------

// File: rtl/cfg_param_pkg.sv
// Shared constant table, index width and FSM state type for the parameter reader.
package cfg_param_pkg;

  localparam int unsigned IDX_W       = 4;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned CNT_W       = 2;
  localparam int unsigned NUM_ENTRIES = 13;

  localparam int CFG_TABLE [NUM_ENTRIES] = '{
    555, 556, 560, 561, 562, 557, 558, 559, 666, 667, 777, 778, 779
  };

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic logic index_valid(input logic [IDX_W-1:0] idx);
    return idx < IDX_W'(NUM_ENTRIES);
  endfunction

  // Out-of-range indices read as zero; loop form avoids indexing past the table.
  function automatic logic [WORD_W-1:0] lookup(input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] word;
    word = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (idx == IDX_W'(i)) word = WORD_W'(CFG_TABLE[i]);
    end
    return word;
  endfunction

endpackage

// File: rtl/param_byte_serializer.sv
// Splits a 32-bit word into four registered bytes with a last flag.
// Optional registered even parity when CFG_PARAM_READER_PARITY_EN is defined.
module param_byte_serializer
  import cfg_param_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              advance,
  output logic [BYTE_W-1:0] data,
  output logic              last
`ifdef CFG_PARAM_READER_PARITY_EN
  ,output logic             par
`endif
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] data_d;
  logic              last_d;

  function automatic logic [BYTE_W-1:0] head(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? w[WORD_W-1 -: BYTE_W] : w[BYTE_W-1:0];
  endfunction

  // Next byte is precomputed so data/last only move on load or a taken byte.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data;
    last_d  = last;
    if (load) begin
      shift_d = word;
      cnt_d   = '0;
      data_d  = head(word);
      last_d  = 1'b0;
    end else if (advance) begin
      shift_d = MSB_FIRST ? (shift_q << BYTE_W) : (shift_q >> BYTE_W);
      if (cnt_q != CNT_W'(3)) cnt_d = cnt_q + CNT_W'(1);
      data_d  = head(shift_d);
      last_d  = (cnt_q == CNT_W'(2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data    <= '0;
      last    <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data    <= data_d;
      last    <= last_d;
    end
  end

`ifdef CFG_PARAM_READER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par <= 1'b0;
    else        par <= ^data_d;
  end
`endif

endmodule

// File: rtl/cfg_param_reader.sv
// Index request in, table constant out as four bytes on a valid/ready stream.
// Define CFG_PARAM_READER_PARITY_EN to add the registered out_par port.
module cfg_param_reader
  import cfg_param_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              out_err
`ifdef CFG_PARAM_READER_PARITY_EN
  ,output logic             out_par
`endif
);

  state_e state_q, state_d;
  logic   req_ready_d, out_valid_d, out_err_d;
  logic   accept, take;

  assign accept = req_valid & req_ready;
  assign take   = out_valid & out_ready;

  // req_ready returns on the same edge that retires the last byte.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready;
    out_valid_d = out_valid;
    out_err_d   = out_err;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          state_d     = SEND;
          req_ready_d = 1'b0;
          out_valid_d = 1'b1;
          out_err_d   = ~index_valid(req_index);
        end
      end
      SEND: begin
        req_ready_d = 1'b0;
        out_valid_d = 1'b1;
        if (take && out_last) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_ready <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= req_ready_d;
      out_valid <= out_valid_d;
      out_err   <= out_err_d;
    end
  end

  param_byte_serializer #(
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .word    (lookup(req_index)),
    .advance (take),
    .data    (out_data),
    .last    (out_last)
`ifdef CFG_PARAM_READER_PARITY_EN
    ,.par    (out_par)
`endif
  );

endmodule

// File: tb/tb_cfg_param_reader.sv
// Directed bench: LSB-first and MSB-first instances driven in lockstep.
module tb_cfg_param_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_index;
  logic       out_ready;

  logic       rdy_l, rdy_m, vld_l, vld_m, last_l, last_m, err_l, err_m;
  logic [7:0] data_l, data_m;
`ifdef CFG_PARAM_READER_PARITY_EN
  logic       par_l, par_m;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cfg_param_reader #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_l),
    .req_index(req_index), .out_valid(vld_l), .out_ready(out_ready),
    .out_data(data_l), .out_last(last_l), .out_err(err_l)
`ifdef CFG_PARAM_READER_PARITY_EN
    ,.out_par(par_l)
`endif
  );

  cfg_param_reader #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_m),
    .req_index(req_index), .out_valid(vld_m), .out_ready(out_ready),
    .out_data(data_m), .out_last(last_m), .out_err(err_m)
`ifdef CFG_PARAM_READER_PARITY_EN
    ,.out_par(par_m)
`endif
  );

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] word;
    logic        err;
    bit          stall;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] el, input logic [7:0] em,
                            input logic lst, input logic err);
    check({tag, " valid"}, 32'({vld_m, vld_l}), 32'h3);
    check({tag, " data_lsb"}, 32'(data_l), 32'(el));
    check({tag, " data_msb"}, 32'(data_m), 32'(em));
    check({tag, " last"}, 32'({last_m, last_l}), lst ? 32'h3 : 32'h0);
    check({tag, " err"}, 32'({err_m, err_l}), err ? 32'h3 : 32'h0);
    check({tag, " req_ready"}, 32'({rdy_m, rdy_l}), 32'h0);
`ifdef CFG_PARAM_READER_PARITY_EN
    check({tag, " par_lsb"}, 32'(par_l), 32'(^el));
    check({tag, " par_msb"}, 32'(par_m), 32'(^em));
`endif
  endtask

  task automatic run_req(input vec_t v);
    int guard = 0;
    logic [7:0] el, em;
    string tag;
    while (!(rdy_l && rdy_m) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("idx%0d req_ready idle", v.idx), 32'({rdy_m, rdy_l}), 32'h3);
    req_valid = 1'b1;
    req_index = v.idx;
    out_ready = !v.stall;
    @(negedge clk);
    req_valid = 1'b0;
    req_index = 4'd0;
    for (int b = 0; b < 4; b++) begin
      el = v.word[8*b +: 8];
      em = v.word[8*(3-b) +: 8];
      tag = $sformatf("idx%0d b%0d", v.idx, b);
      if (v.stall) begin
        out_ready = 1'b0;
        repeat (2) begin
          check_byte({tag, " stall"}, el, em, b == 3, v.err);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      check_byte(tag, el, em, b == 3, v.err);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check($sformatf("idx%0d valid drop", v.idx), 32'({vld_m, vld_l}), 32'h0);
    check($sformatf("idx%0d req_ready back", v.idx), 32'({rdy_m, rdy_l}), 32'h3);
  endtask

  initial begin
    vecs[0] = '{4'd0,  32'h0000_022B, 1'b0, 1'b0};
    vecs[1] = '{4'd12, 32'h0000_030B, 1'b0, 1'b0};
    vecs[2] = '{4'd14, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{4'd8,  32'h0000_029A, 1'b0, 1'b0};
    vecs[4] = '{4'd1,  32'h0000_022C, 1'b0, 1'b1};
    vecs[5] = '{4'd13, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6] = '{4'd15, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{4'd5,  32'h0000_022D, 1'b0, 1'b0};
    vecs[8] = '{4'd10, 32'h0000_0309, 1'b0, 1'b1};
    vecs[9] = '{4'd2,  32'h0000_0230, 1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_index = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset valid", 32'({vld_m, vld_l}), 32'h0);
    check("reset data", 32'({data_m, data_l}), 32'h0);
    check("reset last/err", 32'({last_m, last_l, err_m, err_l}), 32'h0);
    check("reset req_ready", 32'({rdy_m, rdy_l}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", 32'({rdy_m, rdy_l}), 32'h3);
    check("post-reset valid", 32'({vld_m, vld_l}), 32'h0);

    for (int i = 0; i < 10; i++) run_req(vecs[i]);

    // Reset after two bytes of index 9 (0x29B) have been taken.
    req_valid = 1'b1;
    req_index = 4'd9;
    out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst seq b0", 32'(data_l), 32'h9B);
    @(negedge clk);
    check("rst seq b1", 32'(data_l), 32'h02);
    @(negedge clk);
    check("rst seq b2 valid", 32'({vld_m, vld_l}), 32'h3);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async rst valid", 32'({vld_m, vld_l}), 32'h0);
    check("async rst data", 32'({data_m, data_l}), 32'h0);
    check("async rst last/err", 32'({last_m, last_l, err_m, err_l}), 32'h0);
    check("async rst req_ready", 32'({rdy_m, rdy_l}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst release req_ready", 32'({rdy_m, rdy_l}), 32'h3);
    check("rst release valid", 32'({vld_m, vld_l}), 32'h0);
    repeat (2) @(negedge clk);
    check("rst idle valid", 32'({vld_m, vld_l}), 32'h0);
    run_req('{4'd0, 32'h0000_022B, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
